// File: rtl/zoom_pkg.sv
// Shared constants, zoom encoding and FSM states for the zoomed frame reader.
// The origin helpers give the top-left source pixel of the zoom window.
package zoom_pkg;

  localparam int SRC_W           = 160;
  localparam int SRC_H           = 120;
  localparam int ADDR_W          = 15;
  localparam int DATA_W          = 8;
  localparam int FIFO_DEPTH      = 4;
  localparam int MAX_OUTSTANDING = 3;

  typedef enum logic [1:0] {
    ZOOM_1X     = 2'b00,
    ZOOM_2X     = 2'b01,
    ZOOM_4X     = 2'b10,
    ZOOM_1X_ALT = 2'b11
  } zoom_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_e;

  // The window is centred, so the origin is half the frame minus half the window.
  localparam int X0_1X = SRC_W/2 - ((SRC_W/2) >> 0);
  localparam int X0_2X = SRC_W/2 - ((SRC_W/2) >> 1);
  localparam int X0_4X = SRC_W/2 - ((SRC_W/2) >> 2);
  localparam int Y0_1X = SRC_H/2 - ((SRC_H/2) >> 0);
  localparam int Y0_2X = SRC_H/2 - ((SRC_H/2) >> 1);
  localparam int Y0_4X = SRC_H/2 - ((SRC_H/2) >> 2);

  function automatic logic [1:0] zoom_shift(input logic [1:0] sel);
    case (zoom_e'(sel))
      ZOOM_2X: return 2'd1;
      ZOOM_4X: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic int origin_x(input logic [1:0] s);
    case (s)
      2'd1:    return X0_2X;
      2'd2:    return X0_4X;
      default: return X0_1X;
    endcase
  endfunction

  function automatic int origin_y(input logic [1:0] s);
    case (s)
      2'd1:    return Y0_2X;
      2'd2:    return Y0_4X;
      default: return Y0_1X;
    endcase
  endfunction

endpackage

// File: rtl/zoom_pix_fifo.sv
// Small synchronous FIFO holding captured pixels with their sof/eol/eof flags.
// Storage is not reset; only pointers and count are.
module zoom_pix_fifo
  import zoom_pkg::*;
#(
  parameter int W     = 11,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_wdata,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_rdata,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/zoom_frame_reader.sv
// Sweeps the source frame through the memory read port and streams a 1x/2x/4x
// centre-zoomed frame with valid/ready backpressure and a credit-limited read pipeline.
module zoom_frame_reader
  import zoom_pkg::*;
#(
  parameter int SRC_W  = zoom_pkg::SRC_W,
  parameter int SRC_H  = zoom_pkg::SRC_H,
  parameter int ADDR_W = zoom_pkg::ADDR_W,
  parameter int DATA_W = zoom_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        zoom_sel,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof
);

  localparam int XW = $clog2(SRC_W);
  localparam int YW = $clog2(SRC_H);
  localparam int FW = DATA_W + 3;
  localparam int CW = $clog2(FIFO_DEPTH+1);

  state_e      r_state;
  logic [1:0]  r_shift;
  logic [XW-1:0] r_x, r_x0;
  logic [YW-1:0] r_y, r_y0;
  logic        r_inflight;
  logic [2:0]  r_flags;
  logic        r_busy, r_done;

  logic [CW-1:0] w_count;
  logic          w_empty;
  logic [FW-1:0] w_head;
  logic          w_issue, w_pop, w_drained;
  logic          w_x_last, w_y_last;
  logic [XW-1:0] w_sx;
  logic [YW-1:0] w_sy;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]    w_issue_flags;

  assign w_x_last = (r_x == XW'(SRC_W-1));
  assign w_y_last = (r_y == YW'(SRC_H-1));

  // Credit check: captured pixels plus the read in flight; a same-cycle pop earns no credit.
  assign w_issue = (r_state == ST_READ) &&
                   ((w_count + {{(CW-1){1'b0}}, r_inflight}) < CW'(MAX_OUTSTANDING));
  assign w_pop   = !w_empty && pix_ready;

  // The frame ends the cycle after the final handshake, so a pop draining the last entry counts.
  assign w_drained = !r_inflight && ((w_count == '0) || ((w_count == CW'(1)) && w_pop));

  assign w_sx   = r_x0 + (r_x >> r_shift);
  assign w_sy   = r_y0 + (r_y >> r_shift);
  assign w_addr = (ADDR_W'(w_sy) << 7) + (ADDR_W'(w_sy) << 5) + ADDR_W'(w_sx);

  assign w_issue_flags = {w_x_last && w_y_last, w_x_last, (r_x == '0) && (r_y == '0)};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_x0       <= '0;
      r_y0       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      case (r_state)
        ST_IDLE: begin
          if (start && !r_done) begin
            r_shift <= zoom_shift(zoom_sel);
            r_x0    <= XW'(origin_x(zoom_shift(zoom_sel)));
            r_y0    <= YW'(origin_y(zoom_shift(zoom_sel)));
            r_x     <= '0;
            r_y     <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          if (w_issue) begin
            if (w_x_last) begin
              r_x <= '0;
              if (w_y_last) begin
                r_y     <= '0;
                r_state <= ST_DRAIN;
              end else begin
                r_y <= r_y + 1'b1;
              end
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Flags ride one cycle behind the address, matching the memory read latency.
  always_ff @(posedge clk) begin
    r_flags <= w_issue_flags;
  end

  zoom_pix_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_wdata ({r_flags, mem_readdata}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign busy           = r_busy;
  assign done           = r_done;
  assign mem_chipselect = w_issue;
  assign mem_address    = w_issue ? w_addr : '0;
  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_writedata  = '0;

  assign pix_valid = !w_empty;
  assign pix_data  = w_empty ? '0 : w_head[DATA_W-1:0];
  assign pix_sof   = !w_empty && w_head[DATA_W];
  assign pix_eol   = !w_empty && w_head[DATA_W+1];
  assign pix_eof   = !w_empty && w_head[DATA_W+2];

endmodule

// File: tb/tb_zoom_frame_reader.sv
// Bench for zoom_frame_reader: memory model, behavioural reference of the zoomed
// raster, per-cycle compare process and directed timing/boundary checks.
module tb_zoom_frame_reader;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int N  = W*H;
  localparam int AW = 15;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, start, pix_ready;
  logic [1:0]    zoom_sel;
  logic          busy, done, mem_chipselect, mem_clken, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata, mem_readdata, pix_data;
  logic          pix_valid, pix_sof, pix_eol, pix_eof;

  zoom_frame_reader #(.SRC_W(W), .SRC_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .zoom_sel(zoom_sel),
    .busy(busy), .done(done), .mem_address(mem_address),
    .mem_chipselect(mem_chipselect), .mem_clken(mem_clken), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory: registered address, unregistered data.
  logic [7:0]    tbmem [0:32767];
  logic [AW-1:0] r_maddr = '0;
  always @(posedge clk) r_maddr <= mem_address;
  assign mem_readdata = tbmem[r_maddr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_mem(input int pattern);
    for (int a = 0; a < 32768; a++)
      tbmem[a] = (pattern == 0) ? 8'((a ^ (a >> 8)) & 255) : 8'(a & 255);
  endtask

  function automatic int ref_addr(input int s, input int k);
    int x, y, x0, y0;
    x  = k % W;
    y  = k / W;
    x0 = W/2 - ((W/2) >> s);
    y0 = H/2 - ((H/2) >> s);
    return (y0 + (y >> s)) * W + x0 + (x >> s);
  endfunction

  function automatic int ref_beat(input int s, input int k);
    return (k == N-1 ? 1024 : 0) + (k % W == W-1 ? 512 : 0) + (k == 0 ? 256 : 0)
           + int'(tbmem[ref_addr(s, k)]);
  endfunction

  // Reference-model state, owned by the compare process once enabled.
  bit mon_en = 0;
  int m_s = 0;
  int beat_idx, issue_idx, n_sof, n_eol, n_eof;
  bit prev_stall;
  int prev_beat;
  int alog [N];
  int got  [N];

  always @(negedge clk) begin
    if (mon_en) begin
      int cur;
      cur = {pix_eof, pix_eol, pix_sof, pix_data};
      if (mem_chipselect) begin
        if (issue_idx < N) begin
          chk("addr", int'(mem_address), ref_addr(m_s, issue_idx));
          alog[issue_idx] = int'(mem_address);
        end else begin
          chk("extra_read", issue_idx, N-1);
        end
        issue_idx++;
        chk("outstanding_le3", int'((issue_idx - beat_idx) <= 3), 1);
      end
      if (prev_stall) chk("stall_hold", pix_valid ? cur : -1, prev_beat);
      if (pix_valid) begin
        if (beat_idx < N) begin
          chk("beat", cur, ref_beat(m_s, beat_idx));
          if (pix_ready) begin
            got[beat_idx] = int'(pix_data);
            n_sof += int'(pix_sof);
            n_eol += int'(pix_eol);
            n_eof += int'(pix_eof);
          end
        end else begin
          chk("extra_beat", beat_idx, N-1);
        end
        if (pix_ready) beat_idx++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_beat  = cur;
    end
  end

  // Ready driver: 0 = always ready, 1 = ~30% low with occasional long stalls, 2 = held low.
  int rmode = 0;
  int stall_left = 0;
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: pix_ready = 1'b1;
        1: begin
          if (stall_left > 0) begin
            pix_ready = 1'b0;
            stall_left--;
          end else if ($urandom_range(0, 499) == 0) begin
            stall_left = int'($urandom_range(20, 40));
            pix_ready  = 1'b0;
          end else begin
            pix_ready = ($urandom_range(0, 9) >= 3);
          end
        end
        default: pix_ready = 1'b0;
      endcase
    end
  end

  task automatic begin_frame(input int s);
    m_s = s; beat_idx = 0; issue_idx = 0;
    n_sof = 0; n_eol = 0; n_eof = 0;
    prev_stall = 0; prev_beat = 0;
    mon_en = 1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_cs"}, mem_chipselect, 0);
    chk({tag, "_addr"}, int'(mem_address), 0);
    chk({tag, "_data_flags"}, {pix_eof, pix_eol, pix_sof, pix_data}, 0);
    chk({tag, "_consts"}, {mem_clken, mem_write, mem_writedata}, 512);
  endtask

  task automatic frame_totals(input string tag);
    chk({tag, "_beats"}, beat_idx, N);
    chk({tag, "_reads"}, issue_idx, N);
    chk({tag, "_flags"}, n_sof * 10000 + n_eol * 10 + n_eof, 10000 + 1200 + 1);
  endtask

  task automatic run_frame(input logic [1:0] sel, input int s, input int rm, input bit tog,
                           output int t0, output int dcyc);
    begin_frame(s);
    rmode = rm;
    @(posedge clk); #1;
    start = 1'b1; zoom_sel = sel; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    dcyc = -1;
    for (int k = 0; k < 60000; k++) begin
      @(negedge clk);
      if (done) begin dcyc = cyc; break; end
      @(posedge clk); #1;
      if (tog) zoom_sel = 2'($urandom_range(0, 3));
    end
    if (dcyc < 0) chk("done_timeout", 0, 1);
    rmode = 0;
  endtask

  int t0, dcyc, ndone;

  initial begin
    reset = 1'b1; start = 1'b0; zoom_sel = 2'b00;
    load_mem(0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1x frame, always ready, with ignored start pulses at T+10 and on the done cycle.
    begin_frame(0);
    @(posedge clk); #1;
    start = 1'b1; zoom_sel = 2'b00; t0 = cyc;
    dcyc = -1; ndone = 0;
    for (int k = 0; k < 19215; k++) begin
      @(negedge clk);
      if (cyc == t0)     chk("busy_T", busy, 0);
      if (cyc == t0 + 1) begin
        chk("busy_T1", busy, 1);
        chk("cs_T1", mem_chipselect, 1);
        chk("addr_T1", int'(mem_address), 0);
      end
      if (cyc == t0 + 2) chk("valid_T2", pix_valid, 0);
      if (cyc == t0 + 3) chk("valid_T3", pix_valid, 1);
      if (done) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = cyc;
          chk("busy_at_done", busy, 0);
        end
      end
      @(posedge clk); #1;
      start = (cyc == t0 + 10) || (cyc == t0 + 19203);
    end
    start = 1'b0;
    chk("done_cycle_1x", dcyc - t0, 19203);
    chk("done_count_1x", ndone, 1);
    @(negedge clk);
    chk("no_second_frame", busy, 0);
    frame_totals("f1x");
    chk("got0_1x", got[0], 0);
    chk("got256_1x", got[256], 1);
    chk("got_last_1x", got[N-1], 181);

    // 4x frame with zoom_sel toggled throughout.
    load_mem(1);
    run_frame(2'b10, 2, 0, 1'b1, t0, dcyc);
    zoom_sel = 2'b00;
    frame_totals("f4x");
    chk("a4x_00", alog[0], 7260);
    chk("a4x_33", alog[3*W + 3], 7260);
    chk("a4x_40", alog[4], 7261);
    chk("a4x_last", alog[N-1], 11939);

    // zoom_sel=11 behaves as 1x under random backpressure; reset lands mid-stall near beat 5000.
    load_mem(0);
    begin_frame(0);
    rmode = 1;
    @(posedge clk); #1;
    start = 1'b1; zoom_sel = 2'b11;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20000 && beat_idx < 5000; k++) @(negedge clk);
    chk("reached_5000", int'(beat_idx >= 5000), 1);
    rmode = 2;
    repeat (4) @(negedge clk);
    chk("stalled_valid", pix_valid, 1);
    @(posedge clk); #1;
    mon_en = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    rmode = 0;

    // 2x frame after the reset, random backpressure.
    load_mem(1);
    run_frame(2'b01, 1, 1, 1'b0, t0, dcyc);
    frame_totals("f2x");
    chk("a2x_00", alog[0], 4840);
    chk("a2x_10", alog[1], 4840);
    chk("a2x_20", alog[2], 4841);
    chk("a2x_01", alog[W], 4840);
    chk("a2x_02", alog[2*W], 5000);
    chk("a2x_last", alog[N-1], 14359);
    chk("got_last_2x", got[N-1], 14359 & 255);

    repeat (3) @(posedge clk);
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zoom_frame_reader.md
# zoom_frame_reader

Downstream read stage of the coprocessor's dual-port frame memory. It sweeps the 160x120 8-bit grayscale source frame through the memory's second port and emits a 160x120 output pixel stream, zoomed 1x/2x/4x about the frame centre by pixel replication. The stream uses a valid/ready handshake so the display or framebuffer writer can apply backpressure. The block never writes the frame memory.

## Interface
Parameters:
- SRC_W, 160, frame width in pixels
- SRC_H, 120, frame height in pixels
- ADDR_W, 15, frame-memory address width
- DATA_W, 8, pixel width

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a frame; ignored unless IDLE
- zoom_sel  in  2  00=1x, 01=2x, 10=4x, 11 treated as 1x; latched on an accepted start
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse at frame end
- mem_address  out  ADDR_W  read address to the memory's second port
- mem_chipselect  out  1  read strobe
- mem_clken  out  1  constant 1
- mem_write  out  1  constant 0
- mem_writedata  out  DATA_W  constant 0
- mem_readdata  in  DATA_W  valid one cycle after the address is presented (registered address, unregistered q)
- pix_data  out  DATA_W  output pixel
- pix_valid  out  1  pix_data and the sideband flags are valid
- pix_ready  in  1  downstream accepts the beat when pix_valid && pix_ready
- pix_sof  out  1  beat is pixel (0,0)
- pix_eol  out  1  beat has x=SRC_W-1
- pix_eof  out  1  beat is pixel (SRC_W-1, SRC_H-1)

## Operation
- FSM states:
  - IDLE: start moves to READ and latches the zoom shift s (0/1/2).
  - READ: issues reads in raster order over (x,y). After the last address is issued, moves to DRAIN.
  - DRAIN: waits until the FIFO is empty and no read is in flight, then pulses done and returns to IDLE.
- Mapping, with f=2^s:
  - Origin: x0 = SRC_W/2 - (SRC_W/2 >> s), y0 = SRC_H/2 - (SRC_H/2 >> s). This gives 0/0 at 1x, 40/30 at 2x, 60/45 at 4x.
  - Source coordinates: sx = x0 + (x >> s), sy = y0 + (y >> s).
  - Address: sy*160 + sx, computed as (sy<<7)+(sy<<5)+sx in ADDR_W bits. The maximum is 19199, so the address never wraps.
- Read issue:
  - A read is issued (mem_chipselect=1) when outstanding < 3, where outstanding = FIFO count + reads in flight.
  - A pop in the same cycle does not count toward outstanding.
- Capture:
  - mem_readdata is written into a 4-entry FIFO one cycle after issue, together with the sof/eol/eof flags.
  - These flags are computed at issue time and delayed alongside the read.
- pix_valid = FIFO not empty. The stream is fully determined by the FIFO head.
- x wraps 159→0 with y increment. After (159,119) the READ state ends.
- Boundaries:
  - A start while busy is ignored, including the done cycle.
  - A zoom_sel change mid-frame has no effect.
  - The FIFO can never overflow, since outstanding ≤ 3 < 4.
  - If reset is asserted mid-frame, the next cycle is IDLE, the FIFO is empty, the in-flight read is discarded, and counters are 0.
- Reset values: busy, done, pix_valid, pix_sof, pix_eol, pix_eof, mem_chipselect are 0; mem_address is 0; pix_data is 0; mem_clken=1.

## Timing
- start accepted at cycle T:
  - busy=1 from T+1.
  - First address at T+1.
  - First pix_valid at T+3.
- Throughput: one beat per cycle with pix_ready held high. The frame spans 19200 beats; the last beat is at T+19202.
- done=1 and busy=0 in the cycle after the final handshake. A new start is accepted the cycle after done.
- Under stalls, pix_data and flags hold stable while pix_valid && !pix_ready.

## Structure
- zoom_pkg:
  - SRC_W, SRC_H, ADDR_W, DATA_W.
  - Zoom encoding enum and shift lookup.
  - Origin constants per zoom.
  - FSM state enum {IDLE, READ, DRAIN}.
- Sub-module zoom_pix_fifo: 4-entry synchronous FIFO, 11 bits wide (pixel + 3 flags), with count output. The top level holds the FSM, coordinate counters, address arithmetic, in-flight flag, and credit check.

## Test plan
- 1x, mem[a]=(a ^ (a>>8))[7:0], pix_ready=1:
  - Beat i equals mem[i] for all 19200 beats.
  - sof on beat 0, eol on every 160th beat, eof on beat 19199.
  - done at T+19203.
- 2x with mem[a]=a[7:0] and an address tracker:
  - (0,0) and (1,0) read 4840, (2,0) reads 4841.
  - (0,1) reads 4840 and (0,2) reads 5000.
  - (159,119) reads 14359.
- 4x: (0,0)→7260, (3,3)→7260, (4,0)→7261, (159,119)→11939. zoom_sel=11 yields an output identical to 1x.
- Random pix_ready (30% low), including long stalls:
  - Exactly 19200 beats, in order, with no loss or duplication.
  - Data stays stable under stall, and outstanding never exceeds 3.
- reset at beat 5000 mid-stall:
  - All outputs are at reset values the next cycle.
  - A subsequent start at 2x yields a full, correct frame from (0,0).
- start pulses at T+10 and on the done cycle are ignored (no second frame). zoom_sel toggled mid-frame leaves the mapping unchanged.
